// File: rtl/osc_meas_pkg.sv
// Shared types and constants for the oscillator-counter measurement sequencer.
// Includes the bus command decoder used to drive the counter's register port.
package osc_meas_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_SP_WR   = 4'd1,
        S_SP_RD   = 4'd2,
        S_SP_CAP  = 4'd3,
        S_RST_WR  = 4'd4,
        S_RST_WT  = 4'd5,
        S_ST_WR   = 4'd6,
        S_MEAS_WT = 4'd7,
        S_CNT_RD  = 4'd8,
        S_CNT_CAP = 4'd9,
        S_EVAL    = 4'd10,
        S_DONE    = 4'd11,
        S_ABORT   = 4'd12
    } state_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_SP    = 2'd1,
        FLT_DEAD  = 2'd2,
        FLT_ABORT = 2'd3
    } fault_e;

    localparam logic [31:0] ADDR_CNTRLR = 32'd0;
    localparam logic [31:0] ADDR_COUNTR = 32'd1;
    localparam logic [31:0] ADDR_SPR    = 32'd2;
    localparam logic [31:0] CTRL_START  = 32'h0000_0001;
    localparam logic [31:0] CTRL_RESET  = 32'h0000_0002;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    // Bus strobe and payload for the cycle spent in state st; idle bus is all zero.
    function automatic bus_t bus_cmd(input state_e st, input logic [31:0] pattern);
        bus_t b;
        b = '{we: 1'b0, re: 1'b0, addr: 32'h0, wdata: 32'h0};
        case (st)
            S_SP_WR:  begin b.we = 1'b1; b.addr = ADDR_SPR;    b.wdata = pattern;    end
            S_SP_RD:  begin b.re = 1'b1; b.addr = ADDR_SPR;                          end
            S_RST_WR,
            S_ABORT:  begin b.we = 1'b1; b.addr = ADDR_CNTRLR; b.wdata = CTRL_RESET; end
            S_ST_WR:  begin b.we = 1'b1; b.addr = ADDR_CNTRLR; b.wdata = CTRL_START; end
            S_CNT_RD: begin b.re = 1'b1; b.addr = ADDR_COUNTR;                       end
            default:  ;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/osc_meas_stats.sv
// Running sum/min/max over one sequence of counter readings, plus the
// truncated average and its inclusive limit check.
module osc_meas_stats
    import osc_meas_pkg::*;
#(
    parameter int unsigned LOG2_N = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        acc_i,
    input  logic [15:0] cnt_i,
    input  logic [15:0] lim_lo_i,
    input  logic [15:0] lim_hi_i,
    output logic [15:0] avg_o,
    output logic [15:0] min_o,
    output logic [15:0] max_o,
    output logic        in_lim_o,
    output logic        last_o
);

    localparam int unsigned SUM_W = 16 + LOG2_N;

    logic [SUM_W-1:0]  sum_q;
    logic [15:0]       min_q;
    logic [15:0]       max_q;
    logic [LOG2_N-1:0] idx_q;

    // Accumulate one reading per strobe; init restarts the sequence statistics.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= {SUM_W{1'b0}};
            min_q <= 16'h0000;
            max_q <= 16'h0000;
            idx_q <= {LOG2_N{1'b0}};
        end else if (init_i) begin
            sum_q <= {SUM_W{1'b0}};
            min_q <= 16'hFFFF;
            max_q <= 16'h0000;
            idx_q <= {LOG2_N{1'b0}};
        end else if (acc_i) begin
            sum_q <= sum_q + {{LOG2_N{1'b0}}, cnt_i};
            min_q <= (cnt_i < min_q) ? cnt_i : min_q;
            max_q <= (cnt_i > max_q) ? cnt_i : max_q;
            idx_q <= idx_q + LOG2_N'(1'b1);
        end else begin
            sum_q <= sum_q;
            min_q <= min_q;
            max_q <= max_q;
            idx_q <= idx_q;
        end
    end

    assign avg_o    = 16'(sum_q >> LOG2_N);
    assign min_o    = min_q;
    assign max_o    = max_q;
    assign in_lim_o = (lim_lo_i <= avg_o) && (avg_o <= lim_hi_i);
    assign last_o   = &idx_q;

endmodule

// File: rtl/osc_meas_sequencer.sv
// Bus master that checks the counter's scratch pad, runs 2^LOG2_N timed
// reset/start/read measurements on COUNTR and reports the statistics.
module osc_meas_sequencer
    import osc_meas_pkg::*;
#(
    parameter int unsigned LOG2_N     = 2,
    parameter int unsigned RST_WAIT   = 8,
    parameter int unsigned MEAS_WAIT  = 150000,
    parameter logic [31:0] SP_PATTERN = 32'h0000A55A
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic        meas_start,
    input  logic        meas_abort,
    input  logic        cont_mode,
    input  logic [15:0] lim_lo,
    input  logic [15:0] lim_hi,
    output logic [31:0] SEQ_ADDR,
    output logic [31:0] SEQ_DO,
    output logic        SEQ_WE,
    output logic        SEQ_RE,
    input  logic [31:0] SEQ_DI,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] avg_count,
    output logic [15:0] min_count,
    output logic [15:0] max_count,
    output logic [1:0]  fault
);

    localparam int unsigned WAIT_MAX = (MEAS_WAIT > RST_WAIT) ? MEAS_WAIT : RST_WAIT;
    localparam int unsigned WAIT_W   = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q;
    bus_t              bus_q;
    logic              busy_q, done_q, pass_q;
    logic [15:0]       avg_q, min_q, max_q;
    fault_e            fault_q;

    logic        init_s, acc_s, abort_s;
    logic [15:0] cnt_s, st_avg_s, st_min_s, st_max_s;
    logic        st_in_lim_s, st_last_s;
    logic        di_unused_s;

    // The counter only drives the low half of its read data.
    assign cnt_s       = SEQ_DI[15:0];
    assign di_unused_s = ^SEQ_DI[31:16];
    assign abort_s     = meas_abort && (state_q != S_IDLE) && (state_q != S_DONE)
                         && (state_q != S_ABORT);

    osc_meas_stats #(.LOG2_N(LOG2_N)) u_stats (
        .clk_i    (OPB_CLK),
        .rst_i    (OPB_RST),
        .init_i   (init_s),
        .acc_i    (acc_s),
        .cnt_i    (cnt_s),
        .lim_lo_i (lim_lo),
        .lim_hi_i (lim_hi),
        .avg_o    (st_avg_s),
        .min_o    (st_min_s),
        .max_o    (st_max_s),
        .in_lim_o (st_in_lim_s),
        .last_o   (st_last_s)
    );

    // Next-state selection and the statistics strobes; abort pre-empts any capture.
    always_comb begin
        state_d = state_q;
        init_s  = 1'b0;
        acc_s   = 1'b0;
        if (abort_s) begin
            state_d = S_ABORT;
        end else begin
            case (state_q)
                S_IDLE:    state_d = (meas_start && !meas_abort) ? S_SP_WR : S_IDLE;
                S_SP_WR:   state_d = S_SP_RD;
                S_SP_RD:   state_d = S_SP_CAP;
                S_SP_CAP: begin
                    if (cnt_s == SP_PATTERN[15:0]) begin
                        init_s  = 1'b1;
                        state_d = S_RST_WR;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                S_RST_WR:  state_d = S_RST_WT;
                S_RST_WT:  state_d = (wait_q == {WAIT_W{1'b0}}) ? S_ST_WR : S_RST_WT;
                S_ST_WR:   state_d = S_MEAS_WT;
                S_MEAS_WT: state_d = (wait_q == {WAIT_W{1'b0}}) ? S_CNT_RD : S_MEAS_WT;
                S_CNT_RD:  state_d = S_CNT_CAP;
                S_CNT_CAP: begin
                    if (cnt_s == 16'h0000) begin
                        state_d = S_DONE;
                    end else begin
                        acc_s   = 1'b1;
                        state_d = st_last_s ? S_EVAL : S_RST_WR;
                    end
                end
                S_EVAL:    state_d = S_DONE;
                S_DONE: begin
                    if (cont_mode && (fault_q == FLT_NONE)) begin
                        init_s  = 1'b1;
                        state_d = S_RST_WR;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_ABORT:   state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // State, bus and result registers; the bus reflects the state being entered.
    always_ff @(posedge OPB_CLK) begin
        if (OPB_RST) begin
            state_q <= S_IDLE;
            wait_q  <= {WAIT_W{1'b0}};
            bus_q   <= bus_cmd(S_IDLE, SP_PATTERN);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            avg_q   <= 16'h0000;
            min_q   <= 16'h0000;
            max_q   <= 16'h0000;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            bus_q   <= bus_cmd(state_d, SP_PATTERN);
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            // Each wait state lasts exactly its parameter in cycles.
            if ((state_d == S_RST_WT) && (state_q != S_RST_WT)) begin
                wait_q <= WAIT_W'(RST_WAIT - 1);
            end else if ((state_d == S_MEAS_WT) && (state_q != S_MEAS_WT)) begin
                wait_q <= WAIT_W'(MEAS_WAIT - 1);
            end else if (wait_q != {WAIT_W{1'b0}}) begin
                wait_q <= wait_q - WAIT_W'(1'b1);
            end
            if ((state_q == S_IDLE) && (state_d == S_SP_WR)) begin
                fault_q <= FLT_NONE;
            end
            if (state_d == S_DONE) begin
                case (state_q)
                    S_EVAL: begin
                        avg_q  <= st_avg_s;
                        min_q  <= st_min_s;
                        max_q  <= st_max_s;
                        pass_q <= st_in_lim_s;
                    end
                    S_SP_CAP:  begin fault_q <= FLT_SP;    pass_q <= 1'b0; end
                    S_CNT_CAP: begin fault_q <= FLT_DEAD;  pass_q <= 1'b0; end
                    S_ABORT:   begin fault_q <= FLT_ABORT; pass_q <= 1'b0; end
                    default:   ;
                endcase
            end
        end
    end

    assign SEQ_ADDR  = bus_q.addr;
    assign SEQ_DO    = bus_q.wdata;
    assign SEQ_WE    = bus_q.we;
    assign SEQ_RE    = bus_q.re;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign avg_count = avg_q;
    assign min_count = min_q;
    assign max_count = max_q;
    assign fault     = fault_q;

endmodule

// File: doc/osc_meas_sequencer.md
Name: osc_meas_sequencer

Overview:
Bus-master sequencer that drives the oscillator counter peripheral through its register interface.
- Checks the scratch pad first.
- Runs 2^LOG2_N reset/start/wait/read measurement cycles on COUNTR.
- Reports average, min and max counts, and a pass flag against programmable limits.
- Sits beside the counter on the OPB_CLK domain and replaces software polling, because the counter's busy bit is not readable.

Parameters:
- LOG2_N, 2, log2 of measurements per sequence (N=4).
- RST_WAIT, 8, OPB_CLK cycles after the counter-reset write before the start write.
- MEAS_WAIT, 150000, OPB_CLK cycles after the start write before COUNTR is read. Covers CDC latency plus one full 2 kHz REF_CLK window at 100 MHz.
- SP_PATTERN, 32'h0000A55A, scratch-pad test word.

Ports:
- OPB_CLK  in  1  system clock, 100 MHz
- OPB_RST  in  1  reset, synchronous, active-high
- meas_start  in  1  one-cycle request to run a sequence
- meas_abort  in  1  abort the running sequence
- cont_mode  in  1  1 = restart automatically after each completed sequence
- lim_lo  in  16  inclusive lower limit on the average
- lim_hi  in  16  inclusive upper limit on the average
- SEQ_ADDR  out  32  register address to the counter
- SEQ_DO  out  32  write data to the counter
- SEQ_WE  out  1  write strobe to the counter
- SEQ_RE  out  1  read strobe to the counter
- SEQ_DI  in  32  read data from the counter, registered, valid the cycle after SEQ_RE
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- pass  out  1  average within limits and no fault
- avg_count  out  16  sum >> LOG2_N, truncated
- min_count  out  16  smallest count in the sequence
- max_count  out  16  largest count in the sequence
- fault  out  2  0 = none, 1 = scratch mismatch, 2 = ref dead (count 0), 3 = aborted

Behaviour:
- Reset: all outputs 0, state IDLE. Reset mid-sequence returns to IDLE at the next edge; no trailing bus cycle is issued.
- Bus rules:
  - A write is SEQ_WE for 1 cycle with SEQ_ADDR and SEQ_DO valid.
  - A read is SEQ_RE for 1 cycle; SEQ_DI is sampled on the following cycle (CAP state).
  - WE and RE are never both high. ADDR and DO are 0 when no strobe is active.
- Addresses: CNTRLR=0, COUNTR=1, SPR=2. Control words: 0x2 = reset counter, 0x1 = start.
- States and transitions:
  - IDLE: on meas_start, and meas_abort low → SP_WR, clear fault, busy=1 from the next cycle.
  - SP_WR: write SPR = SP_PATTERN → SP_RD.
  - SP_RD: read SPR → SP_CAP.
  - SP_CAP: compare SEQ_DI[15:0] with SP_PATTERN[15:0]. The counter returns only the low 16 bits of SPR. Mismatch → fault=1, go to DONE. Match → init stats (min=FFFF, max=0, sum=0, idx=0) → RST_WR.
  - RST_WR: write CNTRLR=0x2 → RST_WT.
  - RST_WT: wait RST_WAIT cycles → ST_WR.
  - ST_WR: write CNTRLR=0x1 → MEAS_WT.
  - MEAS_WT: wait MEAS_WAIT cycles → CNT_RD.
  - CNT_RD: read COUNTR → CNT_CAP.
  - CNT_CAP: c = SEQ_DI[15:0].
    - c == 0 → fault=2, go to DONE.
    - Else: sum += c; min/max update; idx++.
    - idx wraps to 0 after N−1 → EVAL; otherwise → RST_WR.
  - EVAL: avg = sum[15+LOG2_N:LOG2_N]; pass = lim_lo <= avg <= hi → DONE.
  - DONE: done=1 for 1 cycle.
    - cont_mode=1 and no fault → RST_WR (scratch test skipped, stats re-initialised).
    - Otherwise → IDLE, and busy drops.
- Arithmetic widths:
  - Sum is 16+LOG2_N bits, so no overflow is possible.
  - Wait counter is $clog2(MEAS_WAIT+1) bits, loaded on state entry, terminal at 0.
- Abort:
  - meas_abort in any non-IDLE state except DONE → ABORT state.
  - ABORT issues a single write CNTRLR=0x2, then DONE with fault=3 and pass=0.
  - An in-flight read capture is discarded.
- Simultaneous events:
  - Abort beats start.
  - meas_start while busy is ignored.
  - meas_abort in IDLE is ignored.
- Output holding and update:
  - avg/min/max/pass hold until the next EVAL.
  - On a fault, pass is forced 0 and avg/min/max keep their previous values.
  - fault holds until the next accepted start.
- lim_lo > lim_hi → pass=0 always.

Decomposition:
- Package osc_meas_pkg holds:
  - state enum
  - register address constants CNTRLR/COUNTR/SPR
  - control word constants CTRL_START=0x1, CTRL_RESET=0x2
  - fault codes FLT_NONE/FLT_SP/FLT_DEAD/FLT_ABORT
- Sub-module osc_meas_stats holds:
  - sum/min/max/idx registers, with init and accumulate strobes
  - average shift and limit compare
- The FSM and bus driver remain in the top level.

Test Plan:
- Nominal: counter model returns 50000 each read, lim 49900..50100.
  - → SPR write 0xA55A, then SPR read, then 4× (CNTRLR 0x2, CNTRLR 0x1 after 8 cycles, COUNTR read 150000 cycles later).
  - → done; avg=50000, min=max=50000, pass=1, fault=0.
- Spread: reads return 49990, 50010, 50004, 49996.
  - → avg=50000, min=49990, max=50010, pass=1.
- Out of limits: 4× 51000 with lim 49900..50100.
  - → avg=51000, pass=0, fault=0, done pulse once.
- Scratch fault: model returns 0x0000 on SPR.
  - → fault=1, pass=0, done, zero CNTRLR writes issued.
- Ref dead: second COUNTR read returns 0.
  - → fault=2, done after exactly 2 COUNTR reads, previous avg retained.
- Abort and reset:
  - meas_abort plus meas_start in the same cycle during MEAS_WT → one CNTRLR=0x2 write, fault=3, done, start ignored.
  - OPB_RST asserted mid RST_WT → SEQ_WE, SEQ_RE, busy and all outputs 0 after the next edge.
  - cont_mode=1 → back-to-back sequences with no SPR access after the first.
